// File: rtl/text_pixel_engine.sv
// ============================================================================
// Module  : text_pixel_engine
// Purpose : Text-mode pixel generator: character + glyph lookup, palette
//           colouring, frame-synchronous rotation, attribute blink, cursor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module text_pixel_engine #(
    parameter int GLYPH_BITS   = 3,
    parameter int COLS         = 80,
    parameter int ROWS         = 60,
    parameter int H_VISIBLE    = 640,
    parameter int V_VISIBLE    = 480,
    parameter int COLOR_WIDTH  = 8,
    parameter int CHAR_ADDR_W  = 13,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [9:0]                pixel_counter,
    input  logic [9:0]                line_counter,
    input  logic [1:0]                rot_mode,
    input  logic                      cursor_en,
    input  logic [6:0]                cursor_col,
    input  logic [5:0]                cursor_row,
    input  logic                      pal_we,
    input  logic [3:0]                pal_addr,
    input  logic [COLOR_WIDTH-1:0]    pal_data,
    output logic [CHAR_ADDR_W-1:0]    char_addr,
    input  logic [15:0]               char_data,
    output logic [8+GLYPH_BITS-1:0]   glyph_addr,
    input  logic [(1<<GLYPH_BITS)-1:0] glyph_data,
    output logic [COLOR_WIDTH-1:0]    color
);

    localparam int CELL_W = 10 - GLYPH_BITS;
    localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [9:0]        c_h_vis   = 10'(H_VISIBLE);
    localparam logic [9:0]        c_v_vis   = 10'(V_VISIBLE);
    localparam logic [9:0]        c_cols    = 10'(COLS);
    localparam logic [9:0]        c_rows    = 10'(ROWS);
    localparam logic [FC_W-1:0]   c_fc_last = FC_W'(BLINK_FRAMES - 1);

    // ---------------- stage 0: coordinate decode ----------------
    logic [9:0] w_cell_col;
    logic [9:0] w_cell_row;
    logic       w_visible;
    logic       w_cursor_hit;
    logic       w_frame_evt;

    assign w_cell_col   = {{GLYPH_BITS{1'b0}}, pixel_counter[9:GLYPH_BITS]};
    assign w_cell_row   = {{GLYPH_BITS{1'b0}}, line_counter[9:GLYPH_BITS]};
    assign w_visible    = (pixel_counter < c_h_vis) && (line_counter < c_v_vis) &&
                          (w_cell_col < c_cols) && (w_cell_row < c_rows);
    assign w_cursor_hit = cursor_en && (w_cell_col == {3'b000, cursor_col}) &&
                          (w_cell_row == {4'b0000, cursor_row});
    assign w_frame_evt  = enable && (line_counter == c_v_vis) && (pixel_counter == 10'd0);

    logic [GLYPH_BITS-1:0]  r_s0_x, r_s0_y, r_s1_x, r_s1_y;
    logic                   r_s0_vis, r_s0_cur, r_s0_vld;
    logic                   r_s1_vis, r_s1_cur, r_s1_vld;
    logic [CHAR_ADDR_W-1:0] r_char_addr;

    // ---------------- stage 1: rotation + glyph address ----------------
    logic [1:0]            r_rot;
    logic [GLYPH_BITS-1:0] w_grow, w_gcol;

    always_comb begin
        w_grow = r_s1_y;
        w_gcol = r_s1_x;
        case (r_rot)
            2'd1:    begin w_grow = ~r_s1_x; w_gcol = r_s1_y;  end
            2'd2:    begin w_grow = ~r_s1_y; w_gcol = ~r_s1_x; end
            2'd3:    begin w_grow = r_s1_x;  w_gcol = ~r_s1_y; end
            default: begin w_grow = r_s1_y;  w_gcol = r_s1_x;  end
        endcase
    end

    assign char_addr  = r_char_addr;
    assign glyph_addr = r_s1_vld ? {char_data[7:0], w_grow} : '0;

    // ---------------- stage 2: pixel colour ----------------
    logic [GLYPH_BITS-1:0]  r_s2_col;
    logic [3:0]             r_s2_fg;
    logic [2:0]             r_s2_bg;
    logic                   r_s2_blink, r_s2_vis, r_s2_cur;
    logic                   r_blink_phase;
    logic [FC_W-1:0]        r_frame_cnt;
    logic [COLOR_WIDTH-1:0] r_palette [16];
    logic [COLOR_WIDTH-1:0] r_color;
    logic                   w_fg_bit;
    logic [3:0]             w_pal_idx;

    always_comb begin
        w_fg_bit = glyph_data[r_s2_col];
        if (r_s2_blink && r_blink_phase)
            w_fg_bit = 1'b0;
        if (r_s2_cur && !r_blink_phase)
            w_fg_bit = ~w_fg_bit;
        w_pal_idx = w_fg_bit ? r_s2_fg : {1'b0, r_s2_bg};
    end

    assign color = r_color;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0_x <= '0; r_s0_y <= '0; r_s0_vis <= 1'b0; r_s0_cur <= 1'b0; r_s0_vld <= 1'b0;
            r_s1_x <= '0; r_s1_y <= '0; r_s1_vis <= 1'b0; r_s1_cur <= 1'b0; r_s1_vld <= 1'b0;
            r_s2_col <= '0; r_s2_fg <= '0; r_s2_bg <= '0;
            r_s2_blink <= 1'b0; r_s2_vis <= 1'b0; r_s2_cur <= 1'b0;
            r_char_addr   <= '0;
            r_color       <= '0;
            r_rot         <= 2'd0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_s0_x      <= pixel_counter[GLYPH_BITS-1:0];
            r_s0_y      <= line_counter[GLYPH_BITS-1:0];
            r_s0_vis    <= enable && w_visible;
            r_s0_cur    <= w_cursor_hit;
            r_s0_vld    <= enable;
            r_char_addr <= CHAR_ADDR_W'(32'(w_cell_row) * 32'(COLS) + 32'(w_cell_col));

            // Delay slot matching the character buffer read latency
            r_s1_x   <= r_s0_x;
            r_s1_y   <= r_s0_y;
            r_s1_vis <= enable && r_s0_vis;
            r_s1_cur <= r_s0_cur;
            r_s1_vld <= enable && r_s0_vld;

            r_s2_col   <= w_gcol;
            r_s2_fg    <= char_data[11:8];
            r_s2_bg    <= char_data[14:12];
            r_s2_blink <= char_data[15];
            r_s2_vis   <= enable && r_s1_vis;
            r_s2_cur   <= r_s1_cur;

            r_color <= (enable && r_s2_vis) ? r_palette[w_pal_idx] : '0;

            if (w_frame_evt) begin
                r_rot <= rot_mode;
                if (r_frame_cnt == c_fc_last) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // Palette reads are combinational, so a same-edge write is seen one pixel later
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                r_palette[i] <= (i == 15) ? '1 : '0;
        end else if (pal_we) begin
            r_palette[pal_addr] <= pal_data;
        end
    end

endmodule

`default_nettype wire
